// File: rtl/arts_div_n16_w8_pkg.sv
// arts_div_pkg: shared types, constants and helpers for the segmented
// approximate divider arts_div_n16_w8.
//   state_e  : FSM state encoding (IDLE, DIV, DONE)
//   N, W     : operand width and segment width
//   ITER     : restoring-division iterations per operation
//   seg_sel  : returns {K, segment} for a 16-bit operand
package arts_div_pkg;

  localparam int N    = 16;
  localparam int W    = 8;
  localparam int ITER = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  // K flags a non-zero upper byte; the segment is the leading non-zero byte
  // (or the low byte when the upper one is empty).
  function automatic logic [W:0] seg_sel(input logic [N-1:0] x);
    logic k;
    k = |x[N-1:W];
    return {k, (k ? x[N-1:W] : x[W-1:0])};
  endfunction

endpackage

// File: rtl/arts_div_n16_w8_if.sv
// arts_div_n16_w8_if: valid/ready stream bundle for the approximate divider.
//   in_valid/in_ready/A/B : operand request channel
//   out_valid/out_ready/Q/dz : result channel
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high; a producer holds valid and its payload steady until that
// edge, and ready may be driven without waiting for valid.
// master drives requests and consumes results; slave is the divider side.
interface arts_div_n16_w8_if;
  import arts_div_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Q;
  logic         dz;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Q, dz
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Q, dz
  );

endinterface

// File: rtl/arts_div_n16_w8_div_iter.sv
// div_iter_w8: one combinational restoring-division step.
//   rem_i     : current partial remainder (always below the divisor)
//   num_bit_i : next numerator bit, MSB first
//   div_i     : 8-bit divisor segment
//   rem_o     : updated partial remainder
//   q_o       : quotient bit produced by this step
module div_iter_w8 (
  input  logic [8:0] rem_i,
  input  logic       num_bit_i,
  input  logic [7:0] div_i,
  output logic [8:0] rem_o,
  output logic       q_o
);

  logic [9:0] trial;
  logic [8:0] diff;

  always_comb begin
    trial = {rem_i, num_bit_i};
    // Remainder stays below a 9-bit bound, so the low 9 bits hold the
    // difference whenever the subtraction is taken.
    diff  = trial[8:0] - {1'b0, div_i};
    q_o   = (trial >= {2'b00, div_i});
    rem_o = q_o ? diff : trial[8:0];
  end

endmodule

// File: rtl/arts_div_n16_w8.sv
// arts_div_n16_w8: sequential approximate unsigned divider, 16-bit operands,
// 8-bit dynamic segments. Each operand is reduced to its leading non-zero
// byte; the segment quotient {AS,8'h00}/BS is built one bit per cycle and
// then rescaled by the segment offsets.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the valid/ready stream (A, B in; Q, dz out)
//   dbg_state  : current FSM state, for observation only
// Latency: 17 cycles after accept for divisions, 1 cycle for B==0 / A==0.
module arts_div_n16_w8
  import arts_div_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  arts_div_n16_w8_if.slave    bus,
  output state_e              dbg_state
);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic [8:0]   rem_q,   rem_d;
  // Shared numerator/quotient shift register: numerator bits leave at the
  // MSB while quotient bits enter at the LSB.
  logic [N-1:0] nq_q,    nq_d;
  logic [W-1:0] bs_q,    bs_d;
  logic         ka_q,    ka_d;
  logic         kb_q,    kb_d;
  logic [N-1:0] q_q,     q_d;
  logic         dz_q,    dz_d;

  logic         accept;
  logic         fast_path;
  logic         last_iter;
  logic [W:0]   seg_a;
  logic [W:0]   seg_b;
  logic [8:0]   step_rem;
  logic         step_bit;
  logic [N-1:0] q_full;
  logic [N-1:0] q_recomb;

  div_iter_w8 u_iter (
    .rem_i     (rem_q),
    .num_bit_i (nq_q[N-1]),
    .div_i     (bs_q),
    .rem_o     (step_rem),
    .q_o       (step_bit)
  );

  always_comb begin
    seg_a     = seg_sel(bus.A);
    seg_b     = seg_sel(bus.B);
    accept    = bus.in_valid && (state_q == IDLE);
    fast_path = (bus.B == '0) || (bus.A == '0);
    last_iter = (state_q == DIV) && (cnt_q == 4'(ITER - 1));
    q_full    = {nq_q[N-2:0], step_bit};
    // Rescale: equal offsets cancel the 8-bit numerator pre-shift; a large
    // dividend over a small divisor keeps it; the reverse underflows to 0.
    if (ka_q == kb_q)  q_recomb = q_full >> W;
    else if (ka_q)     q_recomb = q_full;
    else               q_recomb = '0;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)        state_d = fast_path ? DONE : DIV;
      DIV:  if (last_iter)     state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.Q         = q_q;
    bus.dz        = dz_q;
    dbg_state     = state_q;
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    nq_d  = nq_q;
    bs_d  = bs_q;
    ka_d  = ka_q;
    kb_d  = kb_q;
    q_d   = q_q;
    dz_d  = dz_q;
    if (accept) begin
      // The accept edge is the load cycle: operands are reduced here and
      // never sampled again.
      nq_d  = {seg_a[W-1:0], 8'h00};
      bs_d  = seg_b[W-1:0];
      ka_d  = seg_a[W];
      kb_d  = seg_b[W];
      rem_d = '0;
      cnt_d = '0;
      dz_d  = 1'b0;
      if (bus.B == '0) begin
        q_d  = 16'hFFFF;
        dz_d = 1'b1;
      end else if (bus.A == '0) begin
        q_d  = '0;
      end
    end else if (state_q == DIV) begin
      rem_d = step_rem;
      nq_d  = q_full;
      cnt_d = cnt_q + 4'd1;
      if (last_iter) q_d = q_recomb;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      nq_q  <= '0;
      bs_q  <= '0;
      ka_q  <= 1'b0;
      kb_q  <= 1'b0;
      q_q   <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      nq_q  <= nq_d;
      bs_q  <= bs_d;
      ka_q  <= ka_d;
      kb_q  <= kb_d;
      q_q   <= q_d;
      dz_q  <= dz_d;
    end
  end

endmodule

// File: tb/tb_arts_div_n16_w8.sv
module tb_arts_div_n16_w8;
  import arts_div_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;
  int     vectors;
  int     errs;

  arts_div_n16_w8_if bus ();

  arts_div_n16_w8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: returns {dz, Q} ----------------
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    int ka, kb, as_v, bs_v, q;
    if (b == 0) return {1'b1, 16'hFFFF};
    if (a == 0) return 17'd0;
    ka   = (a > 255) ? 1 : 0;
    kb   = (b > 255) ? 1 : 0;
    as_v = ka ? (a / 256) : a;
    bs_v = kb ? (b / 256) : b;
    q    = (as_v * 256) / bs_v;
    if (ka == kb)     q = q / 256;
    else if (ka == 0) q = 0;
    return {1'b0, 16'(q)};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [16:0] ref_v;
    int lat, exp_lat;
    ref_v   = model(a, b);
    exp_lat = (a == 0 || b == 0) ? 1 : 17;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = 16'($urandom);
    bus.B = 16'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("Q", 32'(bus.Q), 32'(ref_v[15:0]));
    chk("dz", 32'(bus.dz), 32'(ref_v[16]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_Q", 32'(bus.Q), 32'(ref_v[15:0]));
      chk("hold_dz", 32'(bus.dz), 32'(ref_v[16]));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("post_handshake_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_handshake_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int spurious;
    logic [15:0] ra, rb;
    vectors = 0;
    errs    = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_Q", 32'(bus.Q), 32'd0);
    chk("reset_dz", 32'(bus.dz), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(16'h1234, 16'h0034, 0);
    chk("q_0x1234_0x34_literal", 32'(bus.Q), 32'h0058);
    run_op(16'd200, 16'd7, 0);
    run_op(16'hFF00, 16'h0100, 0);
    run_op(16'h00FF, 16'h0200, 0);
    run_op(16'h0000, 16'h0005, 0);
    run_op(16'hABCD, 16'h0000, 0);
    run_op(16'h0064, 16'h0005, 0);
    run_op(16'hFFFF, 16'h0001, 0);
    run_op(16'h0000, 16'h0000, 0);

    // Backpressure with ignored in_valid pulses, then a fresh operation
    run_op(16'h1234, 16'h0034, 10);
    run_op(16'h8000, 16'h0003, 0);

    // Reset mid-division
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 16'h4321;
    bus.B = 16'h0011;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midreset_Q", 32'(bus.Q), 32'd0);
    chk("midreset_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) spurious++;
    end
    chk("midreset_no_spurious_result", 32'(spurious), 32'd0);
    run_op(16'h4321, 16'h0011, 0);

    // Randomized operations with random backpressure
    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'($urandom_range(0, 255));
        1: rb = 16'($urandom_range(0, 255));
        2: rb = (n % 3 == 0) ? 16'h0000 : 16'($urandom_range(1, 15));
        3: ra = (n % 4 == 0) ? 16'h0000 : ra;
        default: ;
      endcase
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/arts_div_n16_w8.md
# arts_div_n16_w8

Sequential approximate unsigned divider, 16-bit operands, 8-bit dynamic segments. It is the division counterpart of the team's segmented approximate multiplier. Each operand is reduced to its leading non-zero 8-bit byte. The segment quotient comes from a 16-iteration restoring divider, then shifts back by the segment offsets. It sits behind a valid/ready stream in the approximate-arithmetic datapath.

## Interface
- N, 16: operand and quotient width (fixed; only 16 supported).
- W, 8: segment width (fixed; only 8 supported).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands A, B presented.
- in_ready  out  1  block can accept operands.
- A  in  16  dividend, unsigned.
- B  in  16  divisor, unsigned.
- out_valid  out  1  Q and dz valid.
- out_ready  in  1  consumer accepts result.
- Q  out  16  approximate quotient.
- dz  out  1  divide-by-zero flag for current result.

## Operation
- Segment select on accept, per operand X:
  - Kx = |X[15:8].
  - XS = Kx ? X[15:8] : X[7:0].
- Divider computes q = {AS, 8'h00} / BS.
  - Restoring division, one quotient bit per cycle, MSB first.
  - 16 iterations; 9-bit partial remainder; 16-bit q.
- Result recombination:
  - Ka=Kb: Q = q >> 8.
  - Ka=1, Kb=0: Q = q. Maximum is 0xFF00, so no overflow is possible.
  - Ka=0, Kb=1: Q = 0.
- Fast paths, decided at accept with no iterations:
  - B==0: Q=16'hFFFF, dz=1.
  - A==0 and B!=0: Q=0, dz=0.
- dz=0 for every non-fast-path result.
- States:
  - IDLE: in_ready=1. Accept → DIV, or → DONE on a fast path.
  - DIV: cnt counts 0..15. Each edge performs one iteration. At the edge with cnt==15 → DONE.
  - DONE: out_valid=1. On out_valid && out_ready → IDLE.
- No overlap: in_ready=0 in DIV and DONE. A result cannot be replaced until it is consumed.
- Reset values:
  - state=IDLE.
  - in_ready=1, out_valid=0.
  - Q=0, dz=0, cnt=0.
  - Internal remainder and quotient registers = 0.

## Timing
- Accept on the edge where in_valid && in_ready. A, B are sampled only on that edge and may change afterwards.
- Normal path: out_valid rises 17 cycles after the accept edge.
  - 1 cycle load.
  - 16 cycles iteration.
  - Recombination is registered into Q on the final iteration edge.
- Fast path: out_valid rises 1 cycle after the accept edge.
- Q and dz are stable while out_valid=1 and out_ready=0, indefinitely.
- in_ready rises in the cycle after the out handshake edge. Minimum issue interval: 18 cycles normal, 2 cycles fast path.
- in_valid is ignored while not IDLE. The block never buffers a second request.
- Reset assertion at any time (mid-DIV, or in DONE with a pending result):
  - Immediate return to reset values.
  - The pending result is discarded, and no out_valid follows.
- out_ready while out_valid=0: no effect.

## Structure
- Package arts_div_pkg:
  - state enum {IDLE, DIV, DONE}.
  - Constants N=16, W=8, ITER=16.
  - Function seg_sel returning {K, segment}.
- Sub-module div_iter_w8: one combinational restoring step.
  - Inputs: remainder (9b), next numerator bit, divisor (8b).
  - Outputs: new remainder, quotient bit.
- Top holds the FSM, counter, operand/segment registers and output registers.

## Test plan
- A=0x1234, B=0x0034 (Ka=1, Kb=0, q=0x1200/0x34) → Q=0x0058 (88), dz=0, out_valid 17 cycles after accept.
- A=200, B=7 (Ka=Kb=0) → Q=28; A=0xFF00, B=0x0100 (Ka=Kb=1) → Q=0x00FF.
- A=0x00FF, B=0x0200 → Q=0. A=0, B=5 → Q=0, 1-cycle latency.
- A=0xABCD, B=0 → Q=0xFFFF, dz=1, out_valid 1 cycle after accept; next normal op returns dz=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - Q, dz, out_valid stay constant and in_ready stays 0.
  - in_valid pulses are ignored; the first accept after release yields the correct new result.
- Assert rst_n=0 at iteration 7 of DIV → out_valid=0, in_ready=1 after release, no spurious result; a new op completes correctly.
